// File: rtl/ifq_pkg.sv
// Shared types and default sizing for the multi-issue instruction fetch queue.
package ifq_pkg;

    localparam int          IFQ_DEPTH      = 16;
    localparam int          IFQ_LINE_WORDS = 4;
    localparam int          IFQ_DISP_W     = 2;
    localparam logic [31:0] IFQ_RESET_PC   = 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ifq_entry_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/ifq_ring.sv
// Circular {pc, inst} store: one multi-entry write per cycle, DISP_W
// combinational read ports starting at head, plus occupancy tracking.
module ifq_ring
    import ifq_pkg::*;
#(
    parameter int DEPTH      = IFQ_DEPTH,
    parameter int LINE_WORDS = IFQ_LINE_WORDS,
    parameter int DISP_W     = IFQ_DISP_W
) (
    input  logic                             clk,
    input  logic                             srst,
    input  logic                             flush,
    input  logic [$clog2(LINE_WORDS+1)-1:0]  wr_cnt,
    input  ifq_entry_t                       wr_entry [LINE_WORDS],
    input  logic [$clog2(DISP_W+1)-1:0]      pop_cnt,
    output ifq_entry_t                       rd_entry [DISP_W],
    output logic [DISP_W-1:0]                rd_valid,
    output logic [$clog2(DEPTH):0]           count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ifq_entry_t    mem [DEPTH];
    logic [AW-1:0] head_reg;
    logic [AW-1:0] tail_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] valid_slots;

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_reg + AW'(pop_cnt);
            tail_reg  <= tail_reg + AW'(wr_cnt);
            count_reg <= count_reg + CW'(wr_cnt) - CW'(pop_cnt);
        end
    end

    // Entries land contiguously from tail; pointer arithmetic wraps naturally.
    always_ff @(posedge clk) begin
        if (!srst && !flush) begin
            for (int j = 0; j < LINE_WORDS; j++) begin
                if (j < 32'(wr_cnt)) begin
                    mem[tail_reg + AW'(j)] <= wr_entry[j];
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DISP_W; gi++) begin : g_rd
            assign rd_entry[gi] = mem[head_reg + AW'(gi)];
            assign rd_valid[gi] = count_reg > CW'(gi);
        end
    endgenerate

    assign count = count_reg;

    always_comb begin
        valid_slots = count_reg;
        if (count_reg > CW'(DISP_W)) begin
            valid_slots = CW'(DISP_W);
        end
    end

    // Consuming more than the visible slots would corrupt head/occupancy.
    a_pop_legal : assert property (@(posedge clk) disable iff (srst || flush)
        CW'(pop_cnt) <= valid_slots);

endmodule

// File: rtl/ifq_multi.sv
// Instruction fetch queue: line-at-a-time fetch FSM with redirect handling,
// feeding a ring that presents DISP_W instructions per cycle to dispatch.
module ifq_multi
    import ifq_pkg::*;
#(
    parameter int          DEPTH      = IFQ_DEPTH,
    parameter int          LINE_WORDS = IFQ_LINE_WORDS,
    parameter int          DISP_W     = IFQ_DISP_W,
    parameter logic [31:0] RESET_PC   = IFQ_RESET_PC
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [31:0]                   pc_in,
    output logic                          cache_rd_en,
    output logic                          cache_abort,
    input  logic [32*LINE_WORDS-1:0]      dout,
    input  logic                          dout_valid,
    output logic [32*DISP_W-1:0]          inst,
    output logic [32*DISP_W-1:0]          pc_out,
    output logic [DISP_W-1:0]             inst_valid,
    output logic                          empty,
    input  logic [$clog2(DISP_W+1)-1:0]   inst_rd_cnt,
    input  logic [31:0]                   jmp_branch_address,
    input  logic                          jmp_branch_valid
);

    localparam int          AW         = $clog2(DEPTH);
    localparam int          CW         = AW + 1;
    localparam int          WCW        = $clog2(LINE_WORDS + 1);
    localparam int          OW         = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [31:0] LINE_MASK  = 32'(LINE_WORDS * 4 - 1);
    localparam logic [31:0] LINE_BYTES = 32'(LINE_WORDS * 4);

    fetch_state_t  state_reg;
    fetch_state_t  state_next;
    logic [31:0]   fetch_pc_reg;
    logic [31:0]   fetch_pc_next;
    logic [CW-1:0] count;
    logic [31:0]   line_base;
    logic [31:0]   word_offset;
    logic          can_fetch;
    logic          line_accept;
    logic [WCW-1:0] wr_cnt;
    logic [31:0]   line_words [LINE_WORDS];
    ifq_entry_t    wr_entry [LINE_WORDS];
    ifq_entry_t    rd_entry [DISP_W];

    assign line_base   = fetch_pc_reg & ~LINE_MASK;
    assign word_offset = (fetch_pc_reg & LINE_MASK) >> 2;

    // A request only goes out when a whole line is guaranteed to fit.
    assign can_fetch   = !rst && !jmp_branch_valid && (state_reg == ST_IDLE) &&
                         ((CW'(DEPTH) - count) >= CW'(LINE_WORDS));
    assign line_accept = (state_reg == ST_WAIT) && dout_valid && !jmp_branch_valid;
    assign wr_cnt      = line_accept ? WCW'(32'(LINE_WORDS) - word_offset) : '0;

    genvar gi;
    generate
        for (gi = 0; gi < LINE_WORDS; gi++) begin : g_wr
            logic [OW-1:0] sel;
            assign line_words[gi] = dout[32*gi +: 32];
            // Slot gi takes the word gi places past the entry offset of the fetch PC.
            assign sel          = OW'((word_offset + 32'(gi)) & 32'(LINE_WORDS - 1));
            assign wr_entry[gi] = {line_base | (32'(sel) << 2), line_words[sel]};
        end
        for (gi = 0; gi < DISP_W; gi++) begin : g_disp
            assign inst[32*gi +: 32]   = rd_entry[gi].inst;
            assign pc_out[32*gi +: 32] = rd_entry[gi].pc;
        end
    endgenerate

    ifq_ring #(
        .DEPTH      (DEPTH),
        .LINE_WORDS (LINE_WORDS),
        .DISP_W     (DISP_W)
    ) u_ring (
        .clk      (clk),
        .srst     (rst),
        .flush    (jmp_branch_valid),
        .wr_cnt   (wr_cnt),
        .wr_entry (wr_entry),
        .pop_cnt  (inst_rd_cnt),
        .rd_entry (rd_entry),
        .rd_valid (inst_valid),
        .count    (count)
    );

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        if (jmp_branch_valid) begin
            state_next    = ST_IDLE;
            fetch_pc_next = jmp_branch_address;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (can_fetch) begin
                        state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dout_valid) begin
                        state_next    = ST_IDLE;
                        fetch_pc_next = line_base + LINE_BYTES;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            fetch_pc_reg <= RESET_PC;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
        end
    end

    // The request is raised in the issuing IDLE cycle and held through WAIT.
    assign cache_rd_en = can_fetch || (!rst && (state_reg == ST_WAIT));
    assign cache_abort = !rst && (state_reg == ST_WAIT) && jmp_branch_valid && !dout_valid;
    assign pc_in       = fetch_pc_reg;
    assign empty       = (count == '0);

endmodule

// File: tb/tb_ifq_multi.sv
// Directed bench for ifq_multi: default-size instance for fetch/redirect/flow
// scenarios and a small DEPTH=8/LINE_WORDS=2/DISP_W=1 instance for pointer wrap.
module tb_ifq_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [31:0]  pc_in;
    logic         cache_rd_en;
    logic         cache_abort;
    logic [127:0] dout;
    logic         dout_valid;
    logic [63:0]  inst;
    logic [63:0]  pc_out;
    logic [1:0]   inst_valid;
    logic         empty;
    logic [1:0]   inst_rd_cnt;
    logic [31:0]  jmp_branch_address;
    logic         jmp_branch_valid;

    logic         s_rst;
    logic [31:0]  s_pc_in;
    logic         s_cache_rd_en;
    logic         s_cache_abort;
    logic [63:0]  s_dout;
    logic         s_dout_valid;
    logic [31:0]  s_inst;
    logic [31:0]  s_pc_out;
    logic [0:0]   s_inst_valid;
    logic         s_empty;
    logic [0:0]   s_inst_rd_cnt;
    logic [31:0]  s_jmp_addr;
    logic         s_jmp_valid;

    int errors = 0;
    int checks = 0;

    ifq_multi dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .cache_rd_en(cache_rd_en),
        .cache_abort(cache_abort), .dout(dout), .dout_valid(dout_valid),
        .inst(inst), .pc_out(pc_out), .inst_valid(inst_valid), .empty(empty),
        .inst_rd_cnt(inst_rd_cnt), .jmp_branch_address(jmp_branch_address),
        .jmp_branch_valid(jmp_branch_valid)
    );

    ifq_multi #(.DEPTH(8), .LINE_WORDS(2), .DISP_W(1), .RESET_PC(32'h0)) dut_s (
        .clk(clk), .rst(s_rst), .pc_in(s_pc_in), .cache_rd_en(s_cache_rd_en),
        .cache_abort(s_cache_abort), .dout(s_dout), .dout_valid(s_dout_valid),
        .inst(s_inst), .pc_out(s_pc_out), .inst_valid(s_inst_valid), .empty(s_empty),
        .inst_rd_cnt(s_inst_rd_cnt), .jmp_branch_address(s_jmp_addr),
        .jmp_branch_valid(s_jmp_valid)
    );

    // Cache contents: every instruction word is a fixed tag XOR its own address.
    function automatic logic [31:0] code(input logic [31:0] pc);
        return 32'hC0DE_0000 ^ pc;
    endfunction

    function automatic logic [127:0] line4(input logic [31:0] base);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[32*i +: 32] = code(base + 32'(4*i));
        return r;
    endfunction

    function automatic logic [63:0] line2(input logic [31:0] base);
        logic [63:0] r;
        for (int i = 0; i < 2; i++) r[32*i +: 32] = code(base + 32'(4*i));
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; dout = '0; dout_valid = 1'b0; inst_rd_cnt = '0;
        jmp_branch_address = '0; jmp_branch_valid = 1'b0;
        s_rst = 1'b1; s_dout = '0; s_dout_valid = 1'b0; s_inst_rd_cnt = '0;
        s_jmp_addr = '0; s_jmp_valid = 1'b0;
        repeat (2) tick();
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (inst_valid !== 2'b00) begin errors++; $display("FAIL reset_inst_valid: got %b expected 00", inst_valid); end
        checks++; if (cache_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", cache_rd_en); end
        checks++; if (cache_abort !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b expected 0", cache_abort); end
        checks++; if (pc_in !== 32'h0) begin errors++; $display("FAIL reset_pc_in: got %h expected 00000000", pc_in); end
        rst = 1'b0;
        #1;
        checks++; if (cache_rd_en !== 1'b1) begin errors++; $display("FAIL first_request: got %b expected 1", cache_rd_en); end
        $display("reset released, request pc=%h", pc_in);
    endtask

    task automatic test_first_line();
        tick();
        checks++; if (cache_rd_en !== 1'b1 || pc_in !== 32'h0) begin errors++; $display("FAIL wait_hold: got en=%b pc=%h expected en=1 pc=00000000", cache_rd_en, pc_in); end
        repeat (2) tick();
        dout = line4(32'h0); dout_valid = 1'b1;
        tick();
        dout_valid = 1'b0;
        #1;
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL line0_empty: got %b expected 0", empty); end
        checks++; if (inst_valid !== 2'b11) begin errors++; $display("FAIL line0_valid: got %b expected 11", inst_valid); end
        checks++; if (pc_out !== {32'h4, 32'h0}) begin errors++; $display("FAIL line0_pcs: got %h expected 0000000400000000", pc_out); end
        checks++; if (inst !== {code(32'h4), code(32'h0)}) begin errors++; $display("FAIL line0_inst: got %h expected %h", inst, {code(32'h4), code(32'h0)}); end
        checks++; if (cache_rd_en !== 1'b1 || pc_in !== 32'h10) begin errors++; $display("FAIL line0_next: got en=%b pc=%h expected en=1 pc=00000010", cache_rd_en, pc_in); end
        $display("line 00000000 delivered, slots pc=%h/%h", pc_out[31:0], pc_out[63:32]);
    endtask

    task automatic test_redirect_wait();
        tick();
        jmp_branch_address = 32'h108; jmp_branch_valid = 1'b1;
        #1;
        checks++; if (cache_abort !== 1'b1) begin errors++; $display("FAIL abort_pulse: got %b expected 1", cache_abort); end
        tick();
        jmp_branch_valid = 1'b0;
        #1;
        checks++; if (cache_abort !== 1'b0) begin errors++; $display("FAIL abort_single: got %b expected 0", cache_abort); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL redirect_clear: got %b expected 1", empty); end
        checks++; if (cache_rd_en !== 1'b1 || pc_in !== 32'h108) begin errors++; $display("FAIL redirect_req: got en=%b pc=%h expected en=1 pc=00000108", cache_rd_en, pc_in); end
        tick();
        dout = line4(32'h100); dout_valid = 1'b1;
        tick();
        dout_valid = 1'b0;
        #1;
        checks++; if (pc_out !== {32'h10C, 32'h108}) begin errors++; $display("FAIL partial_pcs: got %h expected 0000010c00000108", pc_out); end
        checks++; if (inst !== {code(32'h10C), code(32'h108)}) begin errors++; $display("FAIL partial_inst: got %h expected %h", inst, {code(32'h10C), code(32'h108)}); end
        checks++; if (pc_in !== 32'h110) begin errors++; $display("FAIL partial_next: got %h expected 00000110", pc_in); end
        inst_rd_cnt = 2'd2;
        tick();
        inst_rd_cnt = 2'd0;
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL partial_count: got empty=%b expected 1", empty); end
        $display("redirect 00000108 done, next fetch pc=%h", pc_in);
    endtask

    task automatic test_fill();
        for (int l = 0; l < 4; l++) begin
            dout = line4(32'h110 + 32'(16*l)); dout_valid = 1'b1;
            tick();
            dout_valid = 1'b0;
            #1;
            $display("fill line %h delivered", 32'h110 + 32'(16*l));
            if (l < 3) begin
                checks++; if (cache_rd_en !== 1'b1 || pc_in !== 32'h120 + 32'(16*l)) begin errors++; $display("FAIL fill_req%0d: got en=%b pc=%h expected en=1 pc=%h", l, cache_rd_en, pc_in, 32'h120 + 32'(16*l)); end
                tick();
            end
        end
        checks++; if (cache_rd_en !== 1'b0) begin errors++; $display("FAIL full_stop: got %b expected 0", cache_rd_en); end
        checks++; if (pc_out[31:0] !== 32'h110) begin errors++; $display("FAIL full_head: got %h expected 00000110", pc_out[31:0]); end
        dout = line4(32'h900); dout_valid = 1'b1;
        tick();
        dout_valid = 1'b0;
        #1;
        checks++; if (pc_in !== 32'h150 || cache_rd_en !== 1'b0) begin errors++; $display("FAIL idle_dout: got en=%b pc=%h expected en=0 pc=00000150", cache_rd_en, pc_in); end
        checks++; if (pc_out[31:0] !== 32'h110) begin errors++; $display("FAIL idle_dout_head: got %h expected 00000110", pc_out[31:0]); end
        inst_rd_cnt = 2'd2;
        tick();
        inst_rd_cnt = 2'd0;
        #1;
        checks++; if (cache_rd_en !== 1'b0) begin errors++; $display("FAIL free2_stop: got %b expected 0", cache_rd_en); end
        checks++; if (pc_out[31:0] !== 32'h118) begin errors++; $display("FAIL pop1_head: got %h expected 00000118", pc_out[31:0]); end
        inst_rd_cnt = 2'd2;
        tick();
        inst_rd_cnt = 2'd0;
        #1;
        checks++; if (cache_rd_en !== 1'b1 || pc_in !== 32'h150) begin errors++; $display("FAIL free4_req: got en=%b pc=%h expected en=1 pc=00000150", cache_rd_en, pc_in); end
        checks++; if (pc_out[31:0] !== 32'h120) begin errors++; $display("FAIL pop2_head: got %h expected 00000120", pc_out[31:0]); end
        $display("fill/drain done, head pc=%h", pc_out[31:0]);
    endtask

    task automatic test_simultaneous();
        inst_rd_cnt = 2'd2;
        repeat (3) tick();
        inst_rd_cnt = 2'd0;
        #1;
        checks++; if (pc_out[31:0] !== 32'h138) begin errors++; $display("FAIL occ6_head: got %h expected 00000138", pc_out[31:0]); end
        dout = line4(32'h150); dout_valid = 1'b1; inst_rd_cnt = 2'd2;
        tick();
        dout_valid = 1'b0; inst_rd_cnt = 2'd0;
        #1;
        checks++; if (pc_out !== {32'h144, 32'h140}) begin errors++; $display("FAIL wr_pop_head: got %h expected 0000014400000140", pc_out); end
        inst_rd_cnt = 2'd2;
        repeat (3) tick();
        inst_rd_cnt = 2'd0;
        #1;
        checks++; if (empty !== 1'b0 || inst_valid !== 2'b11) begin errors++; $display("FAIL occ8_left2: got empty=%b valid=%b expected empty=0 valid=11", empty, inst_valid); end
        checks++; if (pc_out[31:0] !== 32'h158) begin errors++; $display("FAIL occ8_tail: got %h expected 00000158", pc_out[31:0]); end
        inst_rd_cnt = 2'd2;
        tick();
        inst_rd_cnt = 2'd0;
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL occ8_drained: got %b expected 1", empty); end
        $display("write+pop at occupancy 6 done");
    endtask

    task automatic test_redirect_data();
        dout = line4(32'h160); dout_valid = 1'b1;
        tick();
        dout_valid = 1'b0;
        #1;
        checks++; if (inst_valid !== 2'b11 || pc_in !== 32'h170) begin errors++; $display("FAIL pre_redirect: got valid=%b pc=%h expected valid=11 pc=00000170", inst_valid, pc_in); end
        tick();
        dout = line4(32'h170); dout_valid = 1'b1;
        jmp_branch_address = 32'h200; jmp_branch_valid = 1'b1;
        #1;
        checks++; if (cache_abort !== 1'b0) begin errors++; $display("FAIL redirect_data_abort: got %b expected 0", cache_abort); end
        tick();
        dout_valid = 1'b0; jmp_branch_valid = 1'b0;
        #1;
        checks++; if (empty !== 1'b1 || inst_valid !== 2'b00) begin errors++; $display("FAIL redirect_data_drop: got empty=%b valid=%b expected empty=1 valid=00", empty, inst_valid); end
        checks++; if (cache_rd_en !== 1'b1 || pc_in !== 32'h200) begin errors++; $display("FAIL redirect_data_req: got en=%b pc=%h expected en=1 pc=00000200", cache_rd_en, pc_in); end
        $display("redirect with data done, request pc=%h", pc_in);
    endtask

    task automatic test_reset_mid_request();
        tick();
        rst = 1'b1; jmp_branch_address = 32'h300; jmp_branch_valid = 1'b1;
        #1;
        checks++; if (cache_abort !== 1'b0 || cache_rd_en !== 1'b0) begin errors++; $display("FAIL rst_mid_req: got abort=%b en=%b expected abort=0 en=0", cache_abort, cache_rd_en); end
        tick();
        jmp_branch_valid = 1'b0;
        #1;
        checks++; if (pc_in !== 32'h0) begin errors++; $display("FAIL rst_priority: got %h expected 00000000", pc_in); end
        rst = 1'b0;
        #1;
        checks++; if (cache_rd_en !== 1'b1 || pc_in !== 32'h0) begin errors++; $display("FAIL rst_restart: got en=%b pc=%h expected en=1 pc=00000000", cache_rd_en, pc_in); end
        $display("reset during request done");
    endtask

    task automatic test_wrap();
        int          lines;
        int          popped;
        int          cyc;
        logic        pending;
        logic [31:0] exp_pc;
        logic [31:0] exp_line;
        lines = 0; popped = 0; cyc = 0; pending = 1'b0;
        exp_pc = 32'h0; exp_line = 32'h0;
        s_rst = 1'b1;
        repeat (2) tick();
        s_rst = 1'b0;
        while (popped < 80 && cyc < 2000) begin
            #1;
            s_dout_valid = 1'b0;
            s_inst_rd_cnt = 1'b0;
            if (pending) begin
                checks++; if (s_pc_in !== exp_line) begin errors++; $display("FAIL wrap_req_pc: got %h expected %h", s_pc_in, exp_line); end
                s_dout = line2(exp_line); s_dout_valid = 1'b1;
                $display("wrap line %0d pc=%h delivered", lines, exp_line);
                pending = 1'b0; lines++; exp_line += 32'h8;
            end else if (s_cache_rd_en && lines < 40) begin
                pending = 1'b1;
            end
            if (s_inst_valid[0] && (cyc % 3) != 1) begin
                checks++; if (s_pc_out !== exp_pc || s_inst !== code(exp_pc)) begin errors++; $display("FAIL wrap_pop: got pc=%h inst=%h expected pc=%h inst=%h", s_pc_out, s_inst, exp_pc, code(exp_pc)); end
                s_inst_rd_cnt = 1'b1;
                exp_pc += 32'h4; popped++;
            end
            tick();
            cyc++;
        end
        s_dout_valid = 1'b0; s_inst_rd_cnt = 1'b0;
        checks++; if (popped != 80) begin errors++; $display("FAIL wrap_timeout: got %0d entries expected 80", popped); end
        #1;
        checks++; if (s_empty !== 1'b1) begin errors++; $display("FAIL wrap_drained: got %b expected 1", s_empty); end
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_redirect_wait();
        test_fill();
        test_simultaneous();
        test_redirect_data();
        test_reset_mid_request();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifq_multi.md
IFQ_MULTI -- requirements
Module: ifq_multi

Interface
REQ-001 SHALL have parameter DEPTH, default 16, queue entries; power of two, at least 2*LINE_WORDS.
REQ-002 SHALL have parameter LINE_WORDS, default 4, 32-bit instructions per cache line; power of two.
REQ-003 SHALL have parameter DISP_W, default 2, instructions presented to dispatch per cycle; between 1 and LINE_WORDS.
REQ-004 SHALL have parameter RESET_PC, default 32'h0, fetch address after reset.
REQ-005 SHALL have ports: clk in 1, system clock; one clock only.
REQ-006 SHALL have ports: rst in 1, synchronous active-high reset.
REQ-007 SHALL have cache-side ports: pc_in out 32, fetch address; cache_rd_en out 1, read request; cache_abort out 1, cancel pulse; dout in 32*LINE_WORDS, line data, word i at bits [32i+31:32i]; dout_valid in 1, line data valid.
REQ-008 SHALL have dispatch-side ports: inst out 32*DISP_W, instruction slots, slot 0 oldest; pc_out out 32*DISP_W, PC per slot; inst_valid out DISP_W, per-slot valid, thermometer-coded from slot 0; empty out 1, queue empty.
REQ-009 SHALL have dispatch-side ports: inst_rd_cnt in $clog2(DISP_W+1), entries consumed this cycle; jmp_branch_address in 32, redirect target; jmp_branch_valid in 1, redirect strobe.

Function
REQ-010 SHALL store {pc, inst} per entry in a circular buffer; occupancy counter width $clog2(DEPTH)+1.
REQ-011 SHALL run a fetch FSM with states IDLE and WAIT.
REQ-012 IDLE->WAIT when free entries >= LINE_WORDS and no redirect this cycle; cache_rd_en=1 and pc_in=fetch PC, both held stable throughout WAIT.
REQ-013 In WAIT with dout_valid=1: write words offset..LINE_WORDS-1, where offset=fetch_pc[2+:log2(LINE_WORDS)], with pc = line base + 4*i; advance fetch PC to the next line base; go to IDLE.
REQ-014 Minimum request-to-data latency SHALL be one cycle; only one request outstanding.
REQ-015 Dispatch slot k SHALL show entry (head+k) mod DEPTH; inst_valid[k]=1 iff k < occupancy; empty=(occupancy==0).
REQ-016 inst_rd_cnt=n SHALL retire n entries at the clock edge; n > valid slot count is illegal, flagged by an assertion.
REQ-017 Write and pop in the same cycle SHALL both take effect; occupancy += written - n.
REQ-018 Redirect (jmp_branch_valid=1) SHALL clear the queue, ignore pops, discard any dout in that cycle, load fetch PC with jmp_branch_address, and force IDLE.
REQ-019 Redirect while in WAIT with dout_valid=0 SHALL pulse cache_abort for exactly that cycle; otherwise cache_abort=0.
REQ-020 After a redirect in cycle t, cache_rd_en SHALL be 1 in cycle t+1 with pc_in equal to the target.
REQ-021 Head/tail pointers SHALL wrap modulo DEPTH without gaps.
REQ-022 dout_valid in IDLE SHALL be ignored.

Reset
REQ-023 On rst=1 at a clock edge: occupancy 0, pointers 0, FSM IDLE, fetch PC=RESET_PC.
REQ-024 Reset outputs: empty=1, inst_valid=0, cache_rd_en=0, cache_abort=0, pc_in=RESET_PC; inst and pc_out are don't-care while their valid bit is 0.
REQ-025 Reset mid-request SHALL drop the request without cache_abort; rst has priority over redirect.

Structure
REQ-026 Package ifq_pkg SHALL hold ifq_entry_t {pc[31:0], inst[31:0]}, the FSM state enum and the default parameter constants.
REQ-027 The circular storage SHALL be sub-module ifq_ring: multi-word write of up to LINE_WORDS entries, DISP_W read ports, pointers and occupancy; ifq_multi holds the FSM and redirect logic.

Verification
REQ-028 Reset, then line 0x0 returned after 3 cycles -> 4 entries, slots show pc 0x0/0x4, empty=0.
REQ-029 Redirect to 0x108 while in WAIT -> cache_abort pulse, queue cleared, next cycle pc_in=0x108; its line writes 2 entries with pc 0x108 and 0x10C; next request is 0x110.
REQ-030 Sequential fetch with inst_rd_cnt=0 -> requests stop at occupancy 16 (DEPTH=16); cache_rd_en stays 0 until inst_rd_cnt=2 raises free entries to >=4.
REQ-031 dout_valid and inst_rd_cnt=2 together at occupancy 6 -> occupancy 8.
REQ-032 Redirect together with dout_valid -> data dropped, cache_abort=0, empty=1 next cycle.
REQ-033 Run 40 lines at DEPTH=8, LINE_WORDS=2, DISP_W=1 -> pointer wrap is exercised and the PC sequence is in order with no gaps.
